// File: rtl/rv151_marb_pkg.sv
// Shared types for the rv151 memory arbiter: FSM states, read-return tags
// and the default starvation limit for the instruction port.
package rv151_marb_pkg;

   localparam int STV_MAX_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_ARB = 2'd0,
      ST_DRN = 2'd1,
      ST_LCK = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_I    = 2'd1,
      TAG_D    = 2'd2
   } tag_t;

   // A loader access with pl_en low must not write anything.
   function automatic logic [3:0] maskWe(input logic [3:0] we, input logic en);
      return we & {4{en}};
   endfunction

endpackage

// File: rtl/rv151_marb_pri.sv
// I/D priority select with a starvation counter that forces an I grant
// once the instruction port has been refused STV_MAX cycles in a row.
module rv151_marb_pri
   import rv151_marb_pkg::*;
#(
   parameter int STV_MAX = STV_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_arbEn,
   input  logic i_hold,
   input  logic i_piReq,
   input  logic i_pdReq,
   output logic o_gntI,
   output logic o_gntD
);

   localparam int CW = $clog2(STV_MAX + 1);
   localparam logic [CW-1:0] STV_LIM = CW'(STV_MAX);

   logic [CW-1:0] r_stvCnt;

   always_comb begin
      o_gntI = 1'b0;
      o_gntD = 1'b0;
      if (i_arbEn) begin
         if (i_piReq && (r_stvCnt == STV_LIM)) begin
            o_gntI = 1'b1;
         end else if (i_pdReq) begin
            o_gntD = 1'b1;
         end else if (i_piReq) begin
            o_gntI = 1'b1;
         end
      end
   end

   // Counts refused I cycles (including suppressed ARB and drain cycles); frozen while locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stvCnt <= '0;
      end else if (!i_hold) begin
         if (i_piReq && !o_gntI) begin
            if (r_stvCnt != STV_LIM) begin
               r_stvCnt <= r_stvCnt + 1'b1;
            end
         end else begin
            r_stvCnt <= '0;
         end
      end
   end

endmodule

// File: rtl/rv151_marb.sv
// Single-port SRAM arbiter for an instruction port, a data port and an
// exclusive loader that takes the memory over via a lock handshake.
module rv151_marb
   import rv151_marb_pkg::*;
#(
   parameter int STV_MAX = STV_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pi_req,
   input  logic [31:0] pi_ad,
   output logic        pi_gnt,
   output logic        pi_rvl,
   output logic [31:0] pi_rdt,
   input  logic        pd_req,
   input  logic [31:0] pd_ad,
   input  logic [3:0]  pd_we,
   input  logic [31:0] pd_wd,
   output logic        pd_gnt,
   output logic        pd_rvl,
   output logic [31:0] pd_rdt,
   input  logic        pl_lck,
   output logic        pl_ack,
   input  logic        pl_en,
   input  logic [31:0] pl_ad,
   input  logic [3:0]  pl_we,
   input  logic [31:0] pl_wd,
   output logic [31:0] pl_rdt,
   output logic        m_en,
   output logic [31:0] m_ad,
   output logic [3:0]  m_we,
   output logic [31:0] m_wd,
   input  logic [31:0] m_rd
);

   state_t r_state;
   state_t w_stateNxt;
   tag_t   r_tag;
   tag_t   w_tagNxt;
   logic   w_arbEn;
   logic   w_locked;
   logic   w_gntI;
   logic   w_gntD;

   // A lock request seen in ARB already blocks grants in that same cycle.
   assign w_arbEn  = (r_state == ST_ARB) && !pl_lck && !rst;
   assign w_locked = (r_state == ST_LCK) && !rst;

   rv151_marb_pri #(
      .STV_MAX (STV_MAX)
   ) u_pri (
      .clk     (clk),
      .rst     (rst),
      .i_arbEn (w_arbEn),
      .i_hold  (r_state == ST_LCK),
      .i_piReq (pi_req),
      .i_pdReq (pd_req),
      .o_gntI  (w_gntI),
      .o_gntD  (w_gntD)
   );

   always_comb begin
      w_stateNxt = r_state;
      case (r_state)
         ST_ARB:  if (pl_lck) w_stateNxt = ST_DRN;
         ST_DRN:  w_stateNxt = pl_lck ? ST_LCK : ST_ARB;
         ST_LCK:  if (!pl_lck) w_stateNxt = ST_ARB;
         default: w_stateNxt = ST_ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ARB;
      end else begin
         r_state <= w_stateNxt;
      end
   end

   // Writes and loader reads carry no return tag; only granted I/D reads do.
   always_comb begin
      w_tagNxt = TAG_NONE;
      if (w_gntI) begin
         w_tagNxt = TAG_I;
      end else if (w_gntD && (pd_we == 4'h0)) begin
         w_tagNxt = TAG_D;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag <= TAG_NONE;
      end else begin
         r_tag <= w_tagNxt;
      end
   end

   always_comb begin
      m_en = 1'b0;
      m_ad = 32'h0;
      m_we = 4'h0;
      m_wd = 32'h0;
      if (w_gntI) begin
         m_en = 1'b1;
         m_ad = pi_ad;
      end else if (w_gntD) begin
         m_en = 1'b1;
         m_ad = pd_ad;
         m_we = pd_we;
         m_wd = pd_wd;
      end else if (w_locked) begin
         m_en = pl_en;
         m_ad = pl_ad;
         m_we = maskWe(pl_we, pl_en);
         m_wd = pl_wd;
      end
   end

   assign pi_gnt = w_gntI;
   assign pd_gnt = w_gntD;
   assign pi_rvl = (r_tag == TAG_I) && !rst;
   assign pd_rvl = (r_tag == TAG_D) && !rst;
   assign pl_ack = w_locked;
   assign pi_rdt = m_rd;
   assign pd_rdt = m_rd;
   assign pl_rdt = m_rd;

endmodule
